serial_bit_source: RTL and testbench
====================================

// Module: serial_bit_source
// PURPOSE
//  Upstream feeder for the serial sequence detector. Accepts parallel words via valid/ready,
//  shifts them out one bit per clk on x (MSB first by default), and flags valid bits and
//  word completion. Back-to-back words produce a gapless stream, so overlapping patterns
//  that straddle word boundaries reach the detector intact.
// PARAMETERS
//  WIDTH       8   bits per word, 2..32
//  MSB_FIRST   1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//  IDLE_LEVEL  0   value driven on x when no bit is being sent
// PORTS
//  clk        in   1      rising-edge clock; the block's only clock
//  clr        in   1      synchronous, active-high reset
//  din        in   WIDTH  parallel word to serialize
//  din_valid  in   1      din holds a word
//  din_ready  out  1      block can accept a word this cycle
//  x          out  1      serial bit to the detector's x input
//  x_valid    out  1      x carries a payload bit this cycle
//  busy       out  1      a word is being shifted
//  done       out  1      one-cycle pulse, high with the last bit of a word
// BEHAVIOUR
//  - Reset (clr=1 at posedge): state=IDLE, x=IDLE_LEVEL, x_valid=0, busy=0, done=0,
//    shift register and bit counter cleared. clr overrides everything, including mid-word.
//    The partial word is discarded and never resumed.
//  - x, x_valid, busy, done are registered. din_ready is combinational from registered state only:
//    din_ready = (state==IDLE) | (state==SHIFT & cnt==0). No path from din_valid to din_ready.
//  - A word is accepted at a posedge when din_valid & din_ready. din is ignored otherwise.
//    A held din_valid while din_ready=0 is not an error; the word waits.
//  - FSM: IDLE, SHIFT.
//    IDLE : on accept, load shreg<=din and cnt<=WIDTH-1, then go to SHIFT.
//    SHIFT: each cycle presents one bit and decrements cnt.
//           When cnt==0 with accept, reload and stay in SHIFT.
//           When cnt==0 without accept, go to IDLE.
//  - Latency: the first bit appears on x in the cycle after the accept edge.
//    Bit k (k=0..WIDTH-1) appears k+1 cycles after accept. A word occupies exactly WIDTH
//    consecutive x_valid cycles.
//  - MSB_FIRST=1: output order din[WIDTH-1] down to din[0]. MSB_FIRST=0: din[0] up to din[WIDTH-1].
//  - x_valid=1 and busy=1 in every cycle a payload bit is on x.
//    done=1 only in the cycle carrying the last bit.
//  - With back-to-back words (accept on the last-bit cycle), the next first bit follows with
//    no gap: x_valid stays 1 and done pulses once per word.
//  - With no pending word after the last bit, the next cycle has x=IDLE_LEVEL, x_valid=0, busy=0.
//  - cnt width is clog2(WIDTH). The counter never wraps below 0; it is reloaded or the FSM
//    exits at 0.
//  - Words accepted during reset are dropped. Acceptance resumes the first cycle with clr=0,
//    where din_ready=1.
// TESTING
//  1 Reset: clr=1 for 3 clks with din_valid=1 -> x=0, x_valid=0, busy=0, done=0; no word accepted.
//  2 Single word, WIDTH=8, din=8'b1011_0011 -> x = 1,0,1,1,0,0,1,1 on the 8 cycles after accept,
//    x_valid=1 throughout, done only on the 8th cycle, then x_valid=0 and din_ready=1.
//  3 Back-to-back: 8'hC3 then 8'h5A, din_valid held -> 16 contiguous x_valid cycles with bits
//    11000011_01011010, done on cycles 8 and 16, din_ready=1 only on cycles 8 and 16.
//  4 Stall: din_valid=1 with 8'hFF accepted, new din=8'h00 presented during cycles 1-7 ->
//    not accepted until cycle 8; x stays 1 for all 8 bits.
//  5 Mid-word reset: clr=1 during cycle 4 of 8'hF0 -> next cycle x=0, x_valid=0, busy=0,
//    no done pulse; a fresh 8'hAA afterwards serializes fully as 1,0,1,0,1,0,1,0.
//  6 MSB_FIRST=0, din=8'b0000_0110 -> x = 0,1,1,0,0,0,0,0; with the detector attached,
//    y asserts exactly as for the equivalent hand-driven x stream.

Source files
------------

// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder: accepts words over valid/ready and shifts them out one bit per clk.
// Back-to-back words stream with no gap, so patterns spanning word boundaries stay intact.
module serial_bit_source #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             x_nxt, x_valid_nxt, done_nxt;
  logic             accept;

  // First bit of a word goes straight to x at the accept edge; shreg keeps the remainder.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // cnt counts bits still to come after the one on x, so cnt==0 marks the last-bit cycle.
  assign din_ready = (state == IDLE) | ((state == SHIFT) & (cnt == '0));
  assign accept    = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if ((cnt == '0) && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    x_nxt       = IDLE_LEVEL;
    x_valid_nxt = 1'b0;
    done_nxt    = 1'b0;
    if (accept) begin
      x_nxt       = head(din);
      shreg_nxt   = adv(din);
      cnt_nxt     = CW'(WIDTH - 1);
      x_valid_nxt = 1'b1;
    end else if ((state == SHIFT) && (cnt != '0)) begin
      x_nxt       = head(shreg);
      shreg_nxt   = adv(shreg);
      cnt_nxt     = cnt - CW'(1);
      x_valid_nxt = 1'b1;
      done_nxt    = (cnt == CW'(1));
    end else if (state == SHIFT) begin
      shreg_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      shreg   <= '0;
      cnt     <= '0;
      x       <= IDLE_LEVEL;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      x       <= x_nxt;
      x_valid <= x_valid_nxt;
      busy    <= x_valid_nxt;
      done    <= done_nxt;
    end
  end
endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: reset, single word, back-to-back, stall,
// mid-word reset, and an LSB-first instance.
module tb_serial_bit_source;
  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] din, din_l;
  logic       din_valid, din_valid_l;
  logic       din_ready, x, x_valid, busy, done;
  logic       din_ready_l, x_l, x_valid_l, busy_l, done_l;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .clr(clr), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
    .x(x_l), .x_valid(x_valid_l), .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_xv"}, x_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic chk_bit(input string tag, input logic b, input logic d, input logic rdy);
    chk({tag, "_x"}, x, b);
    chk({tag, "_xv"}, x_valid, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done"}, done, d);
    chk({tag, "_rdy"}, din_ready, rdy);
  endtask

  logic [15:0] stream;
  logic [7:0]  w;

  initial begin
    clr = 1'b1; din = 8'hFF; din_valid = 1'b1; din_l = 8'h00; din_valid_l = 1'b0;

    // 1: reset held 3 clocks with din_valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rst");
    end
    clr = 1'b0; din_valid = 1'b0;
    chk("rst_rdy", din_ready, 1);
    tick();
    chk_idle("rst_after");
    chk("rst_after_rdy", din_ready, 1);

    // 2: single word MSB first
    w = 8'b1011_0011;
    din = w; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_bit("single", w[7-i], i == 7, i == 7);
      tick();
    end
    chk_idle("single_end");
    chk("single_end_rdy", din_ready, 1);

    // 3: back-to-back C3 then 5A
    stream = 16'hC35A;
    din = 8'hC3; din_valid = 1'b1;
    tick();
    din = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      chk_bit("b2b", stream[15-i], (i == 7) || (i == 15), (i == 7) || (i == 15));
      if (i == 8) din_valid = 1'b0;
      tick();
    end
    chk_idle("b2b_end");

    // 4: stall; a held 00 word waits until the last bit of FF
    din = 8'hFF; din_valid = 1'b1;
    tick();
    din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_bit("stall", 1'b1, i == 7, i == 7);
      tick();
    end
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_bit("stall2", 1'b0, i == 7, i == 7);
      tick();
    end
    chk_idle("stall_end");

    // 5: reset during the 4th bit of F0, then AA runs cleanly
    din = 8'hF0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_bit("mid", 1'b1, 0, 0);
      tick();
    end
    chk_bit("mid4", 1'b1, 0, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_idle("mid_rst");
    chk("mid_rst_rdy", din_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("mid_quiet");
    end
    w = 8'hAA;
    din = w; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_bit("aa", w[7-i], i == 7, i == 7);
      tick();
    end
    chk_idle("aa_end");

    // 6: LSB-first instance, 0000_0110 -> 0,1,1,0,0,0,0,0
    w = 8'b0000_0110;
    din_l = w; din_valid_l = 1'b1;
    tick();
    din_valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_x", x_l, w[i]);
      chk("lsb_xv", x_valid_l, 1);
      chk("lsb_done", done_l, i == 7);
      tick();
    end
    chk("lsb_end_xv", x_valid_l, 0);
    chk("lsb_end_busy", busy_l, 0);
    chk("lsb_end_rdy", din_ready_l, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
